// File: rtl/cpu_control_sequencer.sv
// cpu_control_sequencer: hardwired fetch/execute control unit with memory handshake
module cpu_control_sequencer (
    input  logic        clk,
    input  logic        clr,
    input  logic        start,
    input  logic [31:0] ir,
    input  logic        mem_ready,
    output logic [15:0] Rin,
    output logic [15:0] Rout,
    output logic        PCout,
    output logic        MARin,
    output logic        IncPC,
    output logic        MDRin,
    output logic        MDRread,
    output logic        MDRout,
    output logic        IRin,
    output logic        Yin,
    output logic        Zin,
    output logic        ZLowSelect,
    output logic        ZHighSelect,
    output logic        ZLOin,
    output logic        ZHIin,
    output logic        ZLOout,
    output logic        ZHIout,
    output logic        HIin,
    output logic        Loin,
    output logic        Cout,
    output logic        PCin,
    output logic        Yout,
    output logic        HIout,
    output logic        Loout,
    output logic        InPortout,
    output logic [4:0]  ALUSelection,
    output logic        mem_read,
    output logic        mem_write,
    output logic        run,
    output logic        illegal
);
    localparam logic [4:0] ALU_ADD = 5'b00011;
    localparam logic [4:0] ALU_AND = 5'b00101;
    localparam logic [4:0] ALU_OR  = 5'b00110;

    typedef enum logic [3:0] {IDLE = 4'd0, F0, F1, F2, E1, E2, E3, E4, E5, E6, HALT} state_t;
    state_t state, state_nxt;

    logic [4:0]  op, alu;
    logic [15:0] ra_oh, rb_oh, rc_oh;
    logic        is_r3, is_imm, is_md, is_neg, is_ld, is_ldi, is_st, is_nop, is_halt;
    logic        r3i, addr, undef, mem_wait;
    logic [2:0]  n_steps;
    logic [3:0]  e_step;
    logic        unused_ir;

    assign op      = ir[31:27];
    assign ra_oh   = 16'd1 << ir[26:23];
    assign rb_oh   = 16'd1 << ir[22:19];
    assign rc_oh   = 16'd1 << ir[18:15];
    assign unused_ir = ^ir[14:0];

    assign is_ld   = op == 5'd0;
    assign is_ldi  = op == 5'd1;
    assign is_st   = op == 5'd2;
    assign is_r3   = op >= 5'd3 && op <= 5'd11;
    assign is_imm  = op >= 5'd12 && op <= 5'd14;
    assign is_md   = op == 5'd15 || op == 5'd16;
    assign is_neg  = op == 5'd17 || op == 5'd18;
    assign is_nop  = op == 5'd24;
    assign is_halt = op == 5'd25;
    assign r3i     = is_r3 || is_imm;
    assign addr    = is_ld || is_ldi || is_st;

    assign n_steps = (r3i || is_ldi) ? 3'd4 : is_md ? 3'd5 : is_neg ? 3'd3 : (is_ld || is_st) ? 3'd6 : 3'd0;
    assign undef   = n_steps == 3'd0 && !is_nop && !is_halt;
    assign alu     = is_imm ? (op == 5'd12 ? ALU_ADD : op == 5'd13 ? ALU_AND : ALU_OR) : addr ? ALU_ADD : op;
    assign e_step  = 4'(state) - 4'd3;
    assign mem_wait = ((state == E5 && is_ld) || (state == E6 && is_st)) && !mem_ready;

    assign run = state != IDLE && state != HALT;
    assign {PCin, Yout, HIout, Loout, InPortout} = '0;

    // State register and sticky illegal-opcode flag
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state   <= IDLE;
            illegal <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == F2 && undef)
                illegal <= 1'b1;
        end
    end

    // Next-state: fetch, opcode dispatch in F2, step through E states until the class's last step
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:                        if (start) state_nxt = F0;
            F0:                          state_nxt = F1;
            F1:                          if (mem_ready) state_nxt = F2;
            F2:                          state_nxt = is_nop ? F0 : (n_steps == 3'd0) ? HALT : E1;
            HALT:                        state_nxt = HALT;
            E1, E2, E3, E4, E5, E6:      state_nxt = mem_wait ? state : (e_step == {1'b0, n_steps}) ? F0 : state_t'(4'(state) + 4'd1);
            default:                     state_nxt = IDLE;
        endcase
    end

    // Datapath control decode from state and IR
    always_comb begin
        Rin  = '0;
        Rout = '0;
        {PCout, MARin, IncPC, MDRin, MDRread, MDRout, IRin, Yin, Zin, ZLowSelect, ZHighSelect,
         ZLOin, ZHIin, ZLOout, ZHIout, HIin, Loin, Cout, mem_read, mem_write} = '0;
        ALUSelection = (state >= E1 && state <= E6) ? alu : 5'd0;
        case (state)
            F0: {PCout, MARin, IncPC} = 3'b111;
            F1: begin
                mem_read = 1'b1;
                MDRread  = mem_ready;
                MDRin    = mem_ready;
            end
            F2: {MDRout, IRin} = 2'b11;
            E1: begin
                Rout = is_md ? ra_oh : rb_oh;
                Yin  = !is_neg;
                Zin  = is_neg;
            end
            E2: begin
                Rout       = is_r3 ? rc_oh : is_md ? rb_oh : '0;
                Cout       = is_imm || addr;
                Zin        = !is_neg;
                ZLowSelect = is_neg;
                ZLOin      = is_neg;
            end
            E3: begin
                ZLowSelect  = !is_neg;
                ZLOin       = !is_neg;
                ZHighSelect = is_md;
                ZHIin       = is_md;
                ZLOout      = is_neg;
                Rin         = is_neg ? ra_oh : '0;
            end
            E4: begin
                ZLOout = 1'b1;
                Rin    = (r3i || is_ldi) ? ra_oh : '0;
                Loin   = is_md;
                MARin  = is_ld || is_st;
            end
            E5: begin
                ZHIout   = is_md;
                HIin     = is_md;
                mem_read = is_ld;
                MDRread  = is_ld && mem_ready;
                MDRin    = (is_ld && mem_ready) || is_st;
                Rout     = is_st ? ra_oh : '0;
            end
            E6: begin
                MDRout    = is_ld;
                Rin       = is_ld ? ra_oh : '0;
                mem_write = is_st;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_cpu_control_sequencer.sv
// tb_cpu_control_sequencer: directed per-cycle vectors checked through an expected-output scoreboard
module tb_cpu_control_sequencer;
    logic        clk = 1'b0, clr, start, mem_ready;
    logic [31:0] ir;
    logic [15:0] Rin, Rout;
    logic PCout, MARin, IncPC, MDRin, MDRread, MDRout, IRin, Yin, Zin, ZLowSelect, ZHighSelect;
    logic ZLOin, ZHIin, ZLOout, ZHIout, HIin, Loin, Cout, PCin, Yout, HIout, Loout, InPortout;
    logic [4:0] ALUSelection;
    logic mem_read, mem_write, run, illegal;

    localparam logic [22:0] PCO = 23'h400000, MAI = 23'h200000, INC = 23'h100000, MDI = 23'h080000,
                            MDR = 23'h040000, MDO = 23'h020000, IRI = 23'h010000, YIN = 23'h008000,
                            ZIN = 23'h004000, ZLS = 23'h002000, ZHS = 23'h001000, ZLI = 23'h000800,
                            ZHI = 23'h000400, ZLO = 23'h000200, ZHO = 23'h000100, HII = 23'h000080,
                            LOI = 23'h000040, COU = 23'h000020, MRD = 23'h000010, MWR = 23'h000008,
                            RUN = 23'h000004, ILL = 23'h000002;

    logic [59:0] obs;
    logic [59:0] exp_q[$];
    string       name_q[$];
    int checks = 0, errors = 0;

    cpu_control_sequencer dut (
        .clk(clk), .clr(clr), .start(start), .ir(ir), .mem_ready(mem_ready),
        .Rin(Rin), .Rout(Rout), .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .MDRin(MDRin),
        .MDRread(MDRread), .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .Zin(Zin),
        .ZLowSelect(ZLowSelect), .ZHighSelect(ZHighSelect), .ZLOin(ZLOin), .ZHIin(ZHIin),
        .ZLOout(ZLOout), .ZHIout(ZHIout), .HIin(HIin), .Loin(Loin), .Cout(Cout), .PCin(PCin),
        .Yout(Yout), .HIout(HIout), .Loout(Loout), .InPortout(InPortout),
        .ALUSelection(ALUSelection), .mem_read(mem_read), .mem_write(mem_write),
        .run(run), .illegal(illegal)
    );

    assign obs = {Rin, Rout, ALUSelection, PCout, MARin, IncPC, MDRin, MDRread, MDRout, IRin, Yin, Zin,
                  ZLowSelect, ZHighSelect, ZLOin, ZHIin, ZLOout, ZHIout, HIin, Loin, Cout,
                  mem_read, mem_write, run, illegal, PCin | Yout | HIout | Loout | InPortout};

    always #5 clk = ~clk;

    // Monitor: mid-cycle, compare the DUT outputs against the oldest expected vector
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [59:0] e;
            string       n;
            e = exp_q.pop_front();
            n = name_q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL %s got %h expected %h", n, obs, e);
            end
        end
    end

    function automatic logic [31:0] mk(input logic [4:0] op, input logic [3:0] ra, rb, rc);
        return {op, ra, rb, rc, 15'd0};
    endfunction

    task automatic e(input logic [15:0] ri, ro, input logic [4:0] alu, input logic [22:0] c, input string n);
        exp_q.push_back({ri, ro, alu, c});
        name_q.push_back(n);
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input int waits);
        e(0, 0, 0, RUN | PCO | MAI | INC, "f0");
        for (int i = 0; i < waits; i++) begin
            mem_ready = 1'b0;
            e(0, 0, 0, RUN | MRD, "f1_wait");
        end
        mem_ready = 1'b1;
        e(0, 0, 0, RUN | MRD | MDI | MDR, "f1_ready");
        e(0, 0, 0, RUN | MDO | IRI, "f2");
    endtask

    initial begin
        clr = 1'b0; start = 1'b0; mem_ready = 1'b0; ir = 32'h19890000;
        @(posedge clk); #1;
        e(0, 0, 0, 0, "reset");
        clr = 1'b1;
        e(0, 0, 0, 0, "idle");
        start = 1'b1;
        e(0, 0, 0, 0, "idle_start");
        start = 1'b0;
        e(0, 0, 0, RUN | PCO | MAI | INC, "f0_first");
        e(0, 0, 0, RUN | MRD, "f1_pre_abort");
        clr = 1'b0;
        e(0, 0, 0, 0, "clr_abort");
        clr = 1'b1; start = 1'b1;
        e(0, 0, 0, 0, "idle_restart");
        start = 1'b0; mem_ready = 1'b1;
        // add R3,R1,R2
        fetch(0);
        e(0, 16'h0002, 5'd3, RUN | YIN, "add_e1");
        e(0, 16'h0004, 5'd3, RUN | ZIN, "add_e2");
        e(0, 0, 5'd3, RUN | ZLS | ZLI, "add_e3");
        e(16'h0008, 0, 5'd3, RUN | ZLO, "add_e4");
        // ld R5,0x10(R2) with a 3-cycle fetch wait and a 1-cycle load wait
        ir = 32'h02900010;
        fetch(3);
        e(0, 16'h0004, 5'd3, RUN | YIN, "ld_e1");
        e(0, 0, 5'd3, RUN | COU | ZIN, "ld_e2");
        e(0, 0, 5'd3, RUN | ZLS | ZLI, "ld_e3");
        e(0, 0, 5'd3, RUN | ZLO | MAI, "ld_e4");
        mem_ready = 1'b0;
        e(0, 0, 5'd3, RUN | MRD, "ld_e5_wait");
        mem_ready = 1'b1;
        e(0, 0, 5'd3, RUN | MRD | MDI | MDR, "ld_e5_ready");
        e(16'h0020, 0, 5'd3, RUN | MDO, "ld_e6");
        // mul R4,R6
        ir = 32'h7A300000;
        fetch(0);
        e(0, 16'h0010, 5'd15, RUN | YIN, "mul_e1");
        e(0, 16'h0040, 5'd15, RUN | ZIN, "mul_e2");
        e(0, 0, 5'd15, RUN | ZLS | ZHS | ZLI | ZHI, "mul_e3");
        e(0, 0, 5'd15, RUN | ZLO | LOI, "mul_e4");
        e(0, 0, 5'd15, RUN | ZHO | HII, "mul_e5");
        // st R7,4(R1) with a 1-cycle write wait; mem_ready low in E5 must be ignored
        ir = mk(5'd2, 4'd7, 4'd1, 4'd0) | 32'd4;
        fetch(0);
        e(0, 16'h0002, 5'd3, RUN | YIN, "st_e1");
        e(0, 0, 5'd3, RUN | COU | ZIN, "st_e2");
        e(0, 0, 5'd3, RUN | ZLS | ZLI, "st_e3");
        e(0, 0, 5'd3, RUN | ZLO | MAI, "st_e4");
        mem_ready = 1'b0;
        e(0, 16'h0080, 5'd3, RUN | MDI, "st_e5");
        e(0, 0, 5'd3, RUN | MWR, "st_e6_wait");
        mem_ready = 1'b1;
        e(0, 0, 5'd3, RUN | MWR, "st_e6_ready");
        // andi R2,R9,imm
        ir = mk(5'd13, 4'd2, 4'd9, 4'd0);
        fetch(0);
        e(0, 16'h0200, 5'd5, RUN | YIN, "andi_e1");
        e(0, 0, 5'd5, RUN | COU | ZIN, "andi_e2");
        e(0, 0, 5'd5, RUN | ZLS | ZLI, "andi_e3");
        e(16'h0004, 0, 5'd5, RUN | ZLO, "andi_e4");
        // neg R1,R14
        ir = mk(5'd17, 4'd1, 4'd14, 4'd0);
        fetch(0);
        e(0, 16'h4000, 5'd17, RUN | ZIN, "neg_e1");
        e(0, 0, 5'd17, RUN | ZLS | ZLI, "neg_e2");
        e(16'h0002, 0, 5'd17, RUN | ZLO, "neg_e3");
        // nop: straight back to fetch
        ir = mk(5'd24, 4'd0, 4'd0, 4'd0);
        fetch(0);
        // undefined opcode 11111 -> HALT with illegal
        ir = mk(5'd31, 4'd0, 4'd0, 4'd0);
        fetch(0);
        e(0, 0, 0, ILL, "halt_illegal");
        start = 1'b1;
        e(0, 0, 0, ILL, "halt_start_ignored");
        start = 1'b0;
        e(0, 0, 0, ILL, "halt_stays");
        clr = 1'b0;
        e(0, 0, 0, 0, "clr_clears_illegal");
        clr = 1'b1;
        e(0, 0, 0, 0, "idle_after_halt");
        repeat (2) @(posedge clk);
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/cpu_control_sequencer.md
# cpu_control_sequencer

Hardwired control unit for the single-bus 32-bit CPU datapath. It steps through instruction fetch and execution and drives one-hot register enables, bus-source selects, ALU operation and Z/HI/LO capture. It also runs a request/ready handshake with memory for every MDR read and write. It sits beside the datapath: IR contents come in, and every datapath control input is produced here.

## Interface
- `ALU_ADD`, 5'b00011: ALUSelection used for address and immediate arithmetic
- `ALU_AND`, 5'b00101: ALUSelection for `andi`
- `ALU_OR`, 5'b00110: ALUSelection for `ori`

Ports:
- `clk`  input  1  single clock; all state changes on the rising edge
- `clr`  input  1  reset, asynchronous, active-low
- `start`  input  1  leave IDLE and begin fetching
- `ir`  input  32  IR register contents; opcode `ir[31:27]`, Ra `[26:23]`, Rb `[22:19]`, Rc `[18:15]`
- `mem_ready`  input  1  memory completes the current read or write this cycle
- `Rin`, `Rout`  output  16  one-hot R0..R15 load enables and bus-source selects
- `PCout`, `MARin`, `IncPC`, `MDRin`, `MDRread`, `MDRout`, `IRin`, `Yin`, `Zin`, `ZLowSelect`, `ZHighSelect`, `ZLOin`, `ZHIin`, `ZLOout`, `ZHIout`, `HIin`, `Loin`, `Cout`  output  1 each  datapath controls
- `PCin`, `Yout`, `HIout`, `Loout`, `InPortout`  output  1 each  tied to 0
- `ALUSelection`  output  5  ALU operation
- `mem_read`, `mem_write`  output  1 each  memory request
- `run`  output  1  high while fetching or executing
- `illegal`  output  1  sticky; set on an undefined opcode

## Operation
- States: IDLE, F0, F1, F2, E1..E6, HALT.
- `clr` low forces IDLE, clears `illegal`, and drives every output to 0.
- IDLE goes to F0 on `start`.
- All outputs decode combinationally from the state and `ir`. Every output not listed for a state is 0.
- Fetch:
  - F0: `PCout`, `MARin`, `IncPC`.
  - F1: `mem_read`. The sequencer stays in F1 while `mem_ready` is 0. When `mem_ready` is 1 it asserts `MDRread` and `MDRin` in that same cycle, then moves to F2.
  - F2: `MDRout`, `IRin`.
- Opcodes and execution steps (`ALUSelection` equals the opcode unless stated otherwise):
  - 3-register ops (add 00011, sub 00100, and 00101, or 00110, ror 00111, rol 01000, shr 01001, shra 01010, shl 01011):
    - E1: `Rout[Rb]`, `Yin`.
    - E2: `Rout[Rc]`, `Zin`.
    - E3: `ZLowSelect`, `ZLOin`.
    - E4: `ZLOout`, `Rin[Ra]`.
  - Immediate ops (addi 01100, andi 01101, ori 01110): same as 3-register ops, except E2 uses `Cout` in place of `Rout[Rc]`. `ALUSelection` is `ALU_ADD`, `ALU_AND` or `ALU_OR` respectively.
  - mul 01111, div 10000:
    - E1: `Rout[Ra]`, `Yin`.
    - E2: `Rout[Rb]`, `Zin`.
    - E3: `ZLowSelect`, `ZHighSelect`, `ZLOin`, `ZHIin`.
    - E4: `ZLOout`, `Loin`.
    - E5: `ZHIout`, `HIin`.
  - neg 10001, not 10010:
    - E1: `Rout[Rb]`, `Zin`.
    - E2: `ZLowSelect`, `ZLOin`.
    - E3: `ZLOout`, `Rin[Ra]`.
  - Address-forming ops (ld 00000, ldi 00001, st 00010) share a prefix, with `ALUSelection` = `ALU_ADD`:
    - E1: `Rout[Rb]`, `Yin`.
    - E2: `Cout`, `Zin`.
    - E3: `ZLowSelect`, `ZLOin`.
    - E4: `ZLOout` together with `MARin` (ld, st) or `Rin[Ra]` (ldi). ldi ends here.
  - ld continues:
    - E5: `mem_read`, waiting on `mem_ready`, with `MDRread`/`MDRin` as in F1.
    - E6: `MDRout`, `Rin[Ra]`.
  - st continues:
    - E5: `Rout[Ra]`, `MDRin` (`MDRread` = 0).
    - E6: `mem_write`, held until `mem_ready`.
  - nop 11000: no execution steps.
  - halt 11001: go to HALT.
  - Any other opcode: go to HALT and set `illegal`.
- After the last step of an instruction the sequencer returns to F0.
- HALT is left only through `clr`.
- `run` = 1 in F0..E6 and 0 in IDLE and HALT.

## Timing
- Execution-step decode after F2 uses the `ir` value captured at the F2 edge.
- Cycle counts, assuming `mem_ready` arrives in the first request cycle:
  - fetch: 3
  - 3-register and immediate ops: 7
  - mul/div: 8
  - neg/not: 6
  - ldi: 7
  - ld and st: 9
  - nop: 3
- Each cycle `mem_ready` is late adds one cycle to F1, E5 (ld) or E6 (st). The request (`mem_read` or `mem_write`) is held steady until then.
- `mem_ready` is ignored in every state other than F1, E5 (ld) and E6 (st).
- `clr` falling during a wait or any other state aborts immediately to IDLE with all outputs 0. No partial completion.
- `start` is ignored outside IDLE.
- `Rin` and `Rout` are never both non-zero for the same register in one cycle, and each has at most one bit set.

## Test plan
- Reset and start: drive `clr` low mid-F1 → all outputs 0, `run` = 0. Release `clr` and pulse `start` → the next cycle shows F0 (`PCout` = `MARin` = `IncPC` = 1).
- add R3,R1,R2: `ir` = 0x19890000, `mem_ready` tied to 1 → 7 cycles; E1 `Rout` = 0x0002 with `Yin`; E2 `Rout` = 0x0004, `ALUSelection` = 00011, `Zin`; E4 `ZLOout` with `Rin` = 0x0008; next cycle F0.
- Fetch wait: `mem_ready` held low for 3 cycles in F1 → `mem_read` high 4 cycles, `MDRin` and `MDRread` high only in the 4th, then F2.
- ld R5,0x10(R2): `ir` = 0x02900010 → E1 `Rout` = 0x0004; E2 `Cout`, `ALUSelection` = 00011; E4 `ZLOout` with `MARin`; E5 `mem_read`; E6 `MDRout` with `Rin` = 0x0020.
- mul R4,R6: `ir` = 0x7A300000 → E1 `Rout` = 0x0010; E2 `Rout` = 0x0040, `Zin`; E3 `ZLOin` and `ZHIin`; E4 `Loin`; E5 `HIin`; 8 cycles total.
- `ir` opcode 11111 → HALT, `illegal` = 1, `run` = 0; `start` has no effect; `clr` low clears `illegal`.
